// File: rtl/pc_hist_unit.sv
// -----------------------------------------------------------------------------
// pc_hist_unit
//
// Program-counter register for the pipelined MIPS core. Each cycle it selects
// the next PC from the externally computed PC+4, a branch target or a jump
// target, and pushes the outgoing PC into a shift-register history. A RUN/HALT
// state machine parks the PC at HALT_PC on a break and, on continue, resumes
// from history entry RESUME_SEL (or RESET_PC if that entry was never filled).
//
// Optional build macro: PC_HIST_PORT_EN
//   When defined, adds a combinational debug read port into the history.
//
// Ports:
//   clk          in   1                      rising-edge clock
//   rst_n        in   1                      asynchronous active-low reset
//   stall        in   1                      hold PC and history (RUN only)
//   pc_src       in   2                      00 PC+4, 01 branch, 10 jump, 11 break
//   brk          in   1                      external break (same as pc_src 11)
//   cont         in   1                      continue, honoured only in HALT
//   pc_plus4     in   XLEN                   sequential target
//   pc_branch    in   XLEN                   branch target
//   pc_jump      in   XLEN                   jump target
//   hist_rd_idx  in   $clog2(HIST_DEPTH)     debug read index (PC_HIST_PORT_EN)
//   hist_rd_data out  XLEN                   hist[hist_rd_idx] (PC_HIST_PORT_EN)
//   pc           out  XLEN                   current PC, registered
//   halted       out  1                      high while in HALT, registered
//   hist_cnt     out  $clog2(HIST_DEPTH+1)   valid history entries, saturating
// -----------------------------------------------------------------------------
module pc_hist_unit #(
    parameter int                XLEN       = 32,
    parameter int                HIST_DEPTH = 5,
    parameter logic [XLEN-1:0]   RESET_PC   = '0,
    parameter logic [XLEN-1:0]   HALT_PC    = '1,
    parameter int                RESUME_SEL = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            stall,
    input  logic [1:0]                      pc_src,
    input  logic                            brk,
    input  logic                            cont,
    input  logic [XLEN-1:0]                 pc_plus4,
    input  logic [XLEN-1:0]                 pc_branch,
    input  logic [XLEN-1:0]                 pc_jump,
`ifdef PC_HIST_PORT_EN
    input  logic [$clog2(HIST_DEPTH)-1:0]   hist_rd_idx,
    output logic [XLEN-1:0]                 hist_rd_data,
`endif
    output logic [XLEN-1:0]                 pc,
    output logic                            halted,
    output logic [$clog2(HIST_DEPTH+1)-1:0] hist_cnt
);

    localparam int CNT_W = $clog2(HIST_DEPTH+1);
    localparam int IDX_W = $clog2(HIST_DEPTH);

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(HIST_DEPTH);
    localparam logic [CNT_W-1:0] RESUME_CNT = CNT_W'(RESUME_SEL);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] hist_q [HIST_DEPTH];
    logic [XLEN-1:0] hist_d [HIST_DEPTH];
    logic            push;

    // Next-state / next-PC selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        case (state_q)
            ST_RUN: begin
                // Break outranks stall so a stalled pipeline can still be halted.
                if (pc_src == 2'b11 || brk) begin
                    pc_d    = HALT_PC;
                    state_d = ST_HALT;
                end else if (!stall) begin
                    case (pc_src)
                        2'b01:   pc_d = pc_branch;
                        2'b10:   pc_d = pc_jump;
                        default: pc_d = pc_plus4;
                    endcase
                    push = 1'b1;
                end
            end
            default: begin
                // Resume only from an entry that was actually written since reset.
                if (cont) begin
                    pc_d    = (cnt_q > RESUME_CNT) ? hist_q[RESUME_SEL] : RESET_PC;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // History shift: hist[0] receives the PC being replaced
    always_comb begin
        hist_d = hist_q;
        cnt_d  = cnt_q;
        if (push) begin
            hist_d[0] = pc_q;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
        end
    end

    assign pc       = pc_q;
    assign halted   = (state_q == ST_HALT);
    assign hist_cnt = cnt_q;

`ifdef PC_HIST_PORT_EN
    // Out-of-range indices fall through to zero.
    always_comb begin
        hist_rd_data = '0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (hist_rd_idx == IDX_W'(i)) begin
                hist_rd_data = hist_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_hist_unit.sv
module tb_pc_hist_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 5;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stall = 1'b1;
    logic [1:0]       pc_src = 2'b00;
    logic             brk = 1'b0;
    logic             cont = 1'b0;
    logic [XLEN-1:0]  pc_plus4 = '0;
    logic [XLEN-1:0]  pc_branch = '0;
    logic [XLEN-1:0]  pc_jump = '0;
    logic [XLEN-1:0]  pc;
    logic             halted;
    logic [CNT_W-1:0] hist_cnt;
`ifdef PC_HIST_PORT_EN
    logic [IDX_W-1:0] hist_rd_idx = '0;
    logic [XLEN-1:0]  hist_rd_data;
`endif

    pc_hist_unit #(
        .XLEN(XLEN), .HIST_DEPTH(DEPTH), .RESET_PC(32'h0),
        .HALT_PC(HALT), .RESUME_SEL(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc_src(pc_src),
        .brk(brk), .cont(cont), .pc_plus4(pc_plus4),
        .pc_branch(pc_branch), .pc_jump(pc_jump),
`ifdef PC_HIST_PORT_EN
        .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data),
`endif
        .pc(pc), .halted(halted), .hist_cnt(hist_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      pc;
        logic             h;
        logic [CNT_W-1:0] cnt;
        string            nm;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        string       nm;
    } rd_t;

    exp_t sb_q[$];
    rd_t  rd_q[$];
    event sample_ev;
    event rd_ev;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: one expectation per clock edge (or per async-reset sample)
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or sample_ev);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({e.nm, ".pc"},       pc,              e.pc);
                chk({e.nm, ".halted"},   {31'b0, halted}, {31'b0, e.h});
                chk({e.nm, ".hist_cnt"}, 32'(hist_cnt),   32'(e.cnt));
            end
        end
    end

    // Monitor for the debug read port
    initial begin
        rd_t r;
        forever begin
            @(rd_ev);
            #1;
            if (rd_q.size() > 0) begin
                r = rd_q.pop_front();
`ifdef PC_HIST_PORT_EN
                chk(r.nm, hist_rd_data, r.data);
`endif
            end
        end
    end

    task automatic step(input logic st, input logic [1:0] src, input logic b, input logic c,
                        input logic [31:0] p4, input logic [31:0] br, input logic [31:0] jp,
                        input logic [31:0] epc, input logic eh, input int ecnt, input string nm);
        exp_t e;
        @(negedge clk);
        stall = st; pc_src = src; brk = b; cont = c;
        pc_plus4 = p4; pc_branch = br; pc_jump = jp;
        e.pc = epc; e.h = eh; e.cnt = CNT_W'(ecnt); e.nm = nm;
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    // Async reset between edges; the following edge is held by stall
    task automatic do_reset(input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        stall = 1'b1; pc_src = 2'b00; brk = 1'b0; cont = 1'b0;
        #1;
        e.pc = 32'h0; e.h = 1'b0; e.cnt = '0; e.nm = nm;
        sb_q.push_back(e);
        ->sample_ev;
        #2;
        rst_n = 1'b1;
        e.nm = {nm, "_hold"};
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic rd_chk(input int idx, input logic [31:0] exp, input string nm);
        rd_t r;
`ifdef PC_HIST_PORT_EN
        #1;
        hist_rd_idx = IDX_W'(idx);
        r.data = exp; r.nm = nm;
        rd_q.push_back(r);
        ->rd_ev;
        #2;
`else
        r.data = exp; r.nm = nm;
        if (idx < 0) rd_q.push_back(r);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("rst0");

        // Sequential fetch, branch, stall
        step(0, 2'b00, 0, 0, 32'h4,  0, 0, 32'h4,  0, 1, "seq1");
        step(0, 2'b00, 0, 0, 32'h8,  0, 0, 32'h8,  0, 2, "seq2");
        step(0, 2'b00, 0, 0, 32'hC,  0, 0, 32'hC,  0, 3, "seq3");
        step(0, 2'b00, 0, 0, 32'h10, 0, 0, 32'h10, 0, 4, "seq4");
        step(0, 2'b01, 0, 0, 32'h14, 32'h40, 32'h90, 32'h40, 0, 5, "branch");
        step(1, 2'b00, 0, 0, 32'h44, 0, 0, 32'h40, 0, 5, "stall1");
        step(1, 2'b01, 0, 0, 32'h44, 32'h80, 0, 32'h40, 0, 5, "stall2");
        // Break wins over stall; HALT ignores everything but cont
        step(1, 2'b11, 0, 0, 32'h44, 0, 0, HALT, 1, 5, "brk_stall");
        step(1, 2'b01, 0, 0, 32'h44, 32'h80, 0, HALT, 1, 5, "halt_t1");
        step(0, 2'b10, 0, 0, 32'h44, 0, 32'h90, HALT, 1, 5, "halt_t2");
        step(0, 2'b00, 1, 0, 32'h44, 0, 0, HALT, 1, 5, "halt_t3");
        // cont beats brk; history pushes were 0,4,8,C,10 -> hist[1] = C
        step(0, 2'b00, 1, 1, 32'h50, 0, 0, 32'hC, 0, 5, "cont_brk");
        step(0, 2'b00, 0, 1, 32'h10, 0, 0, 32'h10, 0, 5, "cont_in_run");
        step(0, 2'b00, 1, 0, 32'h14, 0, 0, HALT, 1, 5, "brk2");
        do_reset("rst_halted");

        // 0 -> 4 -> 8 -> 0x40, break, resume from hist[1] = 4
        step(0, 2'b00, 0, 0, 32'h4, 0, 0, 32'h4, 0, 1, "r_seq1");
        step(0, 2'b00, 0, 0, 32'h8, 0, 0, 32'h8, 0, 2, "r_seq2");
        step(0, 2'b10, 0, 0, 32'hC, 0, 32'h40, 32'h40, 0, 3, "jump");
        step(0, 2'b00, 1, 0, 32'h44, 0, 0, HALT, 1, 3, "brk_ext");
        step(1, 2'b10, 0, 0, 32'h44, 0, 32'h90, HALT, 1, 3, "h_t1");
        step(0, 2'b01, 0, 0, 32'h44, 32'h80, 0, HALT, 1, 3, "h_t2");
        step(1, 2'b11, 0, 0, 32'h44, 0, 0, HALT, 1, 3, "h_t3");
        step(0, 2'b00, 0, 1, 32'h44, 0, 0, 32'h4, 0, 3, "resume_h1");

        // Break right after reset: empty history resumes at RESET_PC
        do_reset("rst_run");
        step(0, 2'b00, 1, 0, 32'h4, 0, 0, HALT, 1, 0, "brk_first");
        step(0, 2'b00, 0, 1, 32'h4, 0, 0, 32'h0, 0, 0, "resume_empty");

        // Seven pushes into depth 5: 0 and 0x100 are dropped
        step(0, 2'b00, 0, 0, 32'h100, 0, 0, 32'h100, 0, 1, "p1");
        step(0, 2'b00, 0, 0, 32'h104, 0, 0, 32'h104, 0, 2, "p2");
        step(0, 2'b00, 0, 0, 32'h108, 0, 0, 32'h108, 0, 3, "p3");
        step(0, 2'b00, 0, 0, 32'h10C, 0, 0, 32'h10C, 0, 4, "p4");
        step(0, 2'b00, 0, 0, 32'h110, 0, 0, 32'h110, 0, 5, "p5");
        step(0, 2'b00, 0, 0, 32'h114, 0, 0, 32'h114, 0, 5, "p6");
        step(0, 2'b00, 0, 0, 32'h118, 0, 0, 32'h118, 0, 5, "p7");
        step(0, 2'b00, 1, 0, 32'h11C, 0, 0, HALT, 1, 5, "brk_full");
        rd_chk(0, 32'h114, "rd0");
        rd_chk(1, 32'h110, "rd1");
        rd_chk(2, 32'h10C, "rd2");
        rd_chk(3, 32'h108, "rd3");
        rd_chk(4, 32'h104, "rd4");
        rd_chk(5, 32'h0,   "rd5_oob");
        rd_chk(7, 32'h0,   "rd7_oob");
        step(0, 2'b00, 0, 1, 32'h11C, 0, 0, 32'h110, 0, 5, "resume_full");

        // Async reset while halted clears history
        step(0, 2'b00, 1, 0, 32'h4, 0, 0, HALT, 1, 5, "brk3");
        do_reset("rst_halted2");
        for (int i = 0; i < DEPTH; i++) rd_chk(i, 32'h0, $sformatf("rd_rst%0d", i));

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #3;
        if (sb_q.size() > 0 || rd_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size() + rd_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_hist_unit.md
Name: pc_hist_unit

Overview:
- Parametrised program-counter register for the pipelined MIPS core; successor to the single-width PC stage with break/continue.
- Selects the next PC from PC+4, branch target or jump target, with stall support.
- Keeps a configurable-depth history of committed PCs.
- Implements an explicit RUN/HALT state machine, so a break parks the PC at a halt address and a continue resumes from a selectable history entry.

Parameters:
- XLEN, 32, PC and target width in bits.
- HIST_DEPTH, 5, number of history entries (≥2).
- RESET_PC, 0, PC value after reset; also the fallback resume target.
- HALT_PC, all ones (XLEN bits), PC value driven while halted.
- RESUME_SEL, 1, history index used on continue (0 = newest entry); must be < HIST_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and history this cycle (RUN only).
- pc_src  in  2  00 = PC+4, 01 = branch, 10 = jump, 11 = break.
- brk  in  1  external break request; same effect as pc_src = 11.
- cont  in  1  continue request, honoured only in HALT.
- pc_plus4  in  XLEN  sequential target.
- pc_branch  in  XLEN  branch target.
- pc_jump  in  XLEN  jump target.
- pc  out  XLEN  current PC, registered.
- halted  out  1  1 while in HALT, registered.
- hist_cnt  out  $clog2(HIST_DEPTH+1)  valid history entries, saturating.

Behaviour:
- Reset (async, rst_n = 0):
  - pc = RESET_PC, state = RUN, halted = 0, hist_cnt = 0.
  - All history entries = 0.
  - Reset takes effect immediately mid-operation, including while in HALT.
- History:
  - Shift register with hist[0] as the newest entry.
  - A push writes the pre-update pc value into hist[0] and shifts the older entries up; hist[HIST_DEPTH-1] is dropped.
  - hist_cnt increments on each push and saturates at HIST_DEPTH.
- RUN, priority order per cycle:
  1. If pc_src == 11 or brk: pc <= HALT_PC, state <= HALT, no push. This applies even when stall = 1.
  2. Else if stall: pc and history hold.
  3. Else: pc <= pc_branch (01), pc_jump (10) or pc_plus4 (00), and push the old pc.
  - cont is ignored in RUN.
- HALT:
  - pc holds HALT_PC.
  - stall, pc_src and brk are ignored, and there is no push.
  - If cont: pc <= hist[RESUME_SEL] when hist_cnt > RESUME_SEL, otherwise RESET_PC; state <= RUN.
  - Resume does not modify history.
  - cont and brk together in HALT: cont wins.
- Latency:
  - Single cycle: the selected target appears on pc the edge after the select.
  - halted rises on the same edge that pc becomes HALT_PC, and falls on the resume edge.
- Width: all targets are XLEN bits, with no arithmetic inside the block. PC+4 is computed externally.

Optional Feature:
- Macro PC_HIST_PORT_EN.
- Defined:
  - Adds input hist_rd_idx, width $clog2(HIST_DEPTH).
  - Adds output hist_rd_data, width XLEN, a combinational read of hist[hist_rd_idx] for the debug unit.
  - An index ≥ HIST_DEPTH returns 0.
- Undefined: both ports are absent and the history is reachable only via resume.

Test Plan:
- Reset, then 3 non-stalled cycles with pc_src = 00 and pc_plus4 = pc+4 -> pc: 0 → 4 → 8 → 12; hist_cnt = 3; hist[0] = 8.
- At pc = 0x10, pc_src = 01 with pc_branch = 0x40 -> next pc = 0x40, hist[0] = 0x10. Then stall = 1 for 2 cycles -> pc stays 0x40, hist_cnt unchanged.
- Sequence 0 → 4 → 8 → 0x40, then brk = 1 -> pc = 0xFFFFFFFF, halted = 1. Over 3 further cycles of pc_src/stall toggling, pc is unchanged. Then cont = 1 -> pc = 0x4 (hist[1]), halted = 0.
- From reset, brk on the first cycle, then cont -> hist_cnt = 0, so pc = RESET_PC = 0.
- Push 7 PCs with HIST_DEPTH = 5 -> hist_cnt = 5, and the oldest 2 PCs are discarded.
- Async reset asserted mid-cycle while halted -> pc = 0 and halted = 0 immediately, without waiting for a clock edge. With PC_HIST_PORT_EN defined, hist_rd_idx = 0..4 reads back all zeros after reset.
